balance_seq: RTL and testbench

- Sequencer between the inertial interface, the PID controller and the motor drive.
- Gates sensor-valid strobes into the PID block (pid_vld) and waits out the PID pipeline latency.
- Scales the captured PID_cntrl by the soft-start timer ss_tmr, then mixes in steering.
- Emits saturated left/right speed commands with a one-cycle spd_vld strobe, plus too_fast and overrun flags.

---
 rtl/balance_pkg.sv | 27 ++
 rtl/steer_mixer.sv | 61 ++++++
 rtl/balance_seq.sv | 142 ++++++++++++++
 tb/tb_balance_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/balance_pkg.sv
// Shared types and helpers for the balance sequencer: FSM state encoding,
// steering pot limits and the 14-to-12-bit signed saturator.
package balance_pkg;

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        ARMED = 3'd1,
        WAIT  = 3'd2,
        SCALE = 3'd3,
        MIX   = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [11:0] STEER_CENTER = 12'h7FF;
    localparam logic [11:0] STEER_MIN    = 12'h200;
    localparam logic [11:0] STEER_MAX    = 12'hE00;

    function automatic logic signed [11:0] sat_s12(input logic signed [13:0] v);
        if (v > 14'sd2047)
            return 12'sh7FF;
        else if (v < -14'sd2048)
            return 12'sh800;
        else
            return v[11:0];
    endfunction

endpackage

// File: rtl/steer_mixer.sv
// Combinational MIX stage: clip and scale the steering pot, add/subtract it
// from the soft-started PID term, saturate, and flag excessive speed.
module steer_mixer
    import balance_pkg::*;
#(
    parameter int TOO_FAST_LIM = 1536
) (
    input  logic [11:0] pid_ss,
    input  logic [11:0] steer_pot,
    input  logic        en_steer,
    input  logic        rider_off,
    output logic [11:0] lft,
    output logic [11:0] rght,
    output logic        too_fast
);

    localparam logic [12:0] LIM = 13'(TOO_FAST_LIM);

    logic        [11:0] clipped;
    logic signed [12:0] err;
    logic signed [13:0] err14;
    logic signed [13:0] err3;
    logic signed [13:0] steer_term;
    logic signed [13:0] pid14;
    logic signed [13:0] lft14;
    logic signed [13:0] rght14;
    logic signed [11:0] lft_sat;
    logic signed [11:0] rght_sat;
    logic        [12:0] lft_mag;
    logic        [12:0] rght_mag;

    always_comb begin
        clipped = steer_pot;
        if (steer_pot < STEER_MIN)
            clipped = STEER_MIN;
        else if (steer_pot > STEER_MAX)
            clipped = STEER_MAX;

        err        = $signed({1'b0, clipped}) - $signed({1'b0, STEER_CENTER});
        err14      = {err[12], err};
        err3       = err14 + (err14 <<< 1);
        // arithmetic shift rounds toward minus infinity
        steer_term = en_steer ? (err3 >>> 4) : 14'sd0;

        pid14  = {{2{pid_ss[11]}}, pid_ss};
        lft14  = pid14 + steer_term;
        rght14 = pid14 - steer_term;

        lft_sat  = rider_off ? 12'sd0 : sat_s12(lft14);
        rght_sat = rider_off ? 12'sd0 : sat_s12(rght14);

        // 13-bit magnitude so that -2048 is representable
        lft_mag  = lft_sat[11]  ? (13'd0 - {lft_sat[11], lft_sat})   : {1'b0, lft_sat};
        rght_mag = rght_sat[11] ? (13'd0 - {rght_sat[11], rght_sat}) : {1'b0, rght_sat};

        lft      = lft_sat;
        rght     = rght_sat;
        too_fast = (lft_mag > LIM) || (rght_mag > LIM);
    end

endmodule

// File: rtl/balance_seq.sv
// Sequencer between inertial sensor, PID and motor drive: gates vld into the
// PID, waits out its latency, soft-start scales, mixes steering, emits speeds.
module balance_seq
    import balance_pkg::*;
#(
    parameter int PID_LAT      = 1,
    parameter int TOO_FAST_LIM = 1536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld,
    input  logic        pwr_up,
    input  logic        rider_off,
    input  logic        en_steer,
    input  logic [11:0] steer_pot,
    input  logic [11:0] PID_cntrl,
    input  logic [7:0]  ss_tmr,
    output logic        pid_vld,
    output logic [11:0] lft_spd,
    output logic [11:0] rght_spd,
    output logic        spd_vld,
    output logic        too_fast,
    output logic        ovr
);

    // The PID result is ready PID_LAT+1 cycles after the pid_vld cycle.
    localparam logic [3:0] WAIT_LOAD = 4'(PID_LAT + 1);

    state_t             state;
    state_t             state_nxt;
    logic        [3:0]  cnt;
    logic               pending;
    logic               accept;
    logic signed [11:0] pid_cap;
    logic signed [11:0] pid_ss;
    logic signed [20:0] prod;
    logic        [11:0] mix_lft;
    logic        [11:0] mix_rght;
    logic               mix_tf;

    // A new PID cycle launches on this edge.
    assign accept = pwr_up && (((state == ARMED) && (vld || pending)) ||
                               ((state == DONE) && pending));

    assign prod = $signed({{9{pid_cap[11]}}, pid_cap}) * $signed({13'd0, ss_tmr});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= OFF;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            OFF:     if (pwr_up) state_nxt = ARMED;
            ARMED:   if (vld || pending) state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = SCALE;
            SCALE:   state_nxt = MIX;
            MIX:     state_nxt = DONE;
            DONE:    state_nxt = pending ? WAIT : ARMED;
            default: state_nxt = OFF;
        endcase
        if (!pwr_up)
            state_nxt = OFF;
    end

    always_comb begin
        spd_vld = (state == DONE);
    end

    steer_mixer #(.TOO_FAST_LIM(TOO_FAST_LIM)) u_mixer (
        .pid_ss    (pid_ss),
        .steer_pot (steer_pot),
        .en_steer  (en_steer),
        .rider_off (rider_off),
        .lft       (mix_lft),
        .rght      (mix_rght),
        .too_fast  (mix_tf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pid_vld  <= 1'b0;
            cnt      <= 4'd0;
            pending  <= 1'b0;
            ovr      <= 1'b0;
            pid_cap  <= 12'sd0;
            pid_ss   <= 12'sd0;
            lft_spd  <= 12'd0;
            rght_spd <= 12'd0;
            too_fast <= 1'b0;
        end else if (!pwr_up) begin
            pid_vld  <= 1'b0;
            cnt      <= 4'd0;
            pending  <= 1'b0;
            ovr      <= 1'b0;
            lft_spd  <= 12'd0;
            rght_spd <= 12'd0;
            too_fast <= 1'b0;
        end else begin
            pid_vld <= accept;

            if (accept)
                cnt <= WAIT_LOAD;
            else if ((state == WAIT) && (cnt != 4'd0))
                cnt <= cnt - 4'd1;

            if ((state == WAIT) && (cnt == 4'd0))
                pid_cap <= PID_cntrl;
            if (state == SCALE)
                pid_ss <= 12'(prod >>> 8);
            if (state == MIX) begin
                lft_spd  <= mix_lft;
                rght_spd <= mix_rght;
                too_fast <= mix_tf;
            end

            // One request may queue behind a busy update; a second is dropped.
            case (state)
                ARMED: pending <= pending && vld;
                WAIT, SCALE, MIX: begin
                    if (vld) begin
                        if (pending) ovr <= 1'b1;
                        else         pending <= 1'b1;
                    end
                end
                DONE: begin
                    if (pending) begin
                        pending <= 1'b0;
                        if (vld) ovr <= 1'b1;
                    end else if (vld) begin
                        pending <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_balance_seq.sv
// Scoreboard bench for balance_seq: directed vectors push expected speeds and
// strobe cycles; a negedge monitor pops and compares on pid_vld / spd_vld.
module tb_balance_seq;

    localparam int PID_LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic        pwr_up = 1'b0;
    logic        rider_off = 1'b0;
    logic        en_steer = 1'b0;
    logic [11:0] steer_pot = 12'h7FF;
    logic [11:0] pid_cntrl = 12'h000;
    logic [7:0]  ss_tmr = 8'd0;
    logic        pid_vld;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        spd_vld;
    logic        too_fast;
    logic        ovr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // {lft[11:0], rght[11:0], too_fast, spd_vld cycle[31:0]}
    logic [56:0] exp_q[$];
    logic [31:0] pid_q[$];
    logic [56:0] mon_e;
    logic [31:0] mon_p;

    balance_seq #(.PID_LAT(PID_LAT), .TOO_FAST_LIM(1536)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld       (vld),
        .pwr_up    (pwr_up),
        .rider_off (rider_off),
        .en_steer  (en_steer),
        .steer_pot (steer_pot),
        .PID_cntrl (pid_cntrl),
        .ss_tmr    (ss_tmr),
        .pid_vld   (pid_vld),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .spd_vld   (spd_vld),
        .too_fast  (too_fast),
        .ovr       (ovr)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (pid_vld) begin
                if (pid_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pid_vld_unexpected: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_p = pid_q.pop_front();
                    check("pid_vld_cycle", cyc, mon_p);
                end
            end
            if (spd_vld) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spd_vld_unexpected: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("lft_spd", 32'(lft_spd), 32'(mon_e[56:45]));
                    check("rght_spd", 32'(rght_spd), 32'(mon_e[44:33]));
                    check("too_fast", 32'(too_fast), 32'(mon_e[32]));
                    check("spd_vld_cycle", cyc, mon_e[31:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic set_in(input logic [11:0] pid, input logic [7:0] ss, input logic [11:0] pot,
                          input logic en, input logic roff);
        pid_cntrl = pid;
        ss_tmr    = ss;
        steer_pot = pot;
        en_steer  = en;
        rider_off = roff;
    endtask

    // vld is sampled on posedge number edge_k
    task automatic vld_at(input int edge_k);
        while (cyc < edge_k - 1) @(negedge clk);
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic push_exp(input logic [11:0] l, input logic [11:0] r, input logic tf, input int c);
        exp_q.push_back({l, r, tf, c});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && pid_q.size() == 0) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d/%0d pending expected 0", exp_q.size(), pid_q.size());
        exp_q.delete();
        pid_q.delete();
    endtask

    task automatic txn(input logic [11:0] l, input logic [11:0] r, input logic tf);
        int k;
        k = cyc + 1;
        pid_q.push_back(k);
        push_exp(l, r, tf, k + PID_LAT + 4);
        vld_at(k);
        wait_drain();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_lft"}, 32'(lft_spd), 32'h0);
        check({tag, "_rght"}, 32'(rght_spd), 32'h0);
        check({tag, "_too_fast"}, 32'(too_fast), 32'h0);
        check({tag, "_ovr"}, 32'(ovr), 32'h0);
        check({tag, "_pid_vld"}, 32'(pid_vld), 32'h0);
        check({tag, "_spd_vld"}, 32'(spd_vld), 32'h0);
    endtask

    initial begin
        #200000;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int k;
        int d;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n  = 1'b1;
        pwr_up = 1'b1;
        repeat (2) @(negedge clk);

        // basic update, no steering
        set_in(12'h100, 8'd255, 12'h7FF, 1'b0, 1'b0);
        txn(12'h0FF, 12'h0FF, 1'b0);

        // reset while in MIX, then unpowered vld pulses are ignored
        set_in(12'h7FF, 8'd255, 12'hFFF, 1'b1, 1'b0);
        k = cyc + 1;
        pid_q.push_back(k);
        vld_at(k);
        while (cyc < k + PID_LAT + 3) @(negedge clk);
        rst_n  = 1'b0;
        pwr_up = 1'b0;
        #1;
        check_idle("mid_mix_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vld_at(cyc + 2);
        end
        repeat (10) @(negedge clk);
        check_idle("pwr_off");
        pwr_up = 1'b1;
        repeat (2) @(negedge clk);

        // soft-start scale of a negative PID, then rider off
        set_in(12'hC00, 8'd128, 12'h7FF, 1'b0, 1'b0);
        txn(12'hE00, 12'hE00, 1'b0);
        rider_off = 1'b1;
        txn(12'h000, 12'h000, 1'b0);

        // steering only, clipped pot; then steering disabled
        set_in(12'h000, 8'd255, 12'hFFF, 1'b1, 1'b0);
        txn(12'h120, 12'hEE0, 1'b0);
        en_steer = 1'b0;
        txn(12'h000, 12'h000, 1'b0);

        // positive and negative saturation
        set_in(12'h7FF, 8'd255, 12'hFFF, 1'b1, 1'b0);
        txn(12'h7FF, 12'h6D7, 1'b1);
        set_in(12'h800, 8'd255, 12'h000, 1'b1, 1'b0);
        txn(12'h800, 12'h928, 1'b1);

        // steering term rounds toward minus infinity
        set_in(12'h000, 8'd0, 12'h7FE, 1'b1, 1'b0);
        txn(12'hFFF, 12'h001, 1'b0);

        // too_fast threshold: 1536 is not too fast, 1537 is
        set_in(12'h600, 8'd255, 12'h81F, 1'b1, 1'b0);
        txn(12'h600, 12'h5F4, 1'b0);
        steer_pot = 12'h825;
        txn(12'h601, 12'h5F3, 1'b1);

        // vld during SCALE queues a second update
        set_in(12'h100, 8'd255, 12'h7FF, 1'b0, 1'b0);
        k = cyc + 1;
        d = k + PID_LAT + 4;
        pid_q.push_back(k);
        pid_q.push_back(d + 1);
        push_exp(12'h0FF, 12'h0FF, 1'b0, d);
        push_exp(12'h0FF, 12'h0FF, 1'b0, d + PID_LAT + 5);
        vld_at(k);
        vld_at(k + PID_LAT + 3);
        wait_drain();
        check("ovr_after_one_queued", 32'(ovr), 32'h0);

        // vld in SCALE and again in MIX: second one is dropped
        set_in(12'hC00, 8'd128, 12'h7FF, 1'b0, 1'b0);
        k = cyc + 1;
        d = k + PID_LAT + 4;
        pid_q.push_back(k);
        pid_q.push_back(d + 1);
        push_exp(12'hE00, 12'hE00, 1'b0, d);
        push_exp(12'hE00, 12'hE00, 1'b0, d + PID_LAT + 5);
        vld_at(k);
        vld_at(k + PID_LAT + 3);
        vld_at(k + PID_LAT + 4);
        wait_drain();
        check("ovr_after_drop", 32'(ovr), 32'h1);
        repeat (3) @(negedge clk);
        check("ovr_sticky", 32'(ovr), 32'h1);

        // power drop during WAIT aborts the update and clears ovr
        set_in(12'h100, 8'd255, 12'h7FF, 1'b0, 1'b0);
        k = cyc + 1;
        pid_q.push_back(k);
        vld_at(k);
        pwr_up = 1'b0;
        @(negedge clk);
        check_idle("pwr_drop_wait");
        repeat (8) @(negedge clk);
        check_idle("pwr_drop_hold");

        wait_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
